// File: rtl/audio_stream_sequencer_if.sv
// Valid/ready sample stream between the audio core, the sequencer and the DAC path.
interface audio_stream_sequencer_if #(
    parameter int unsigned DATA_W = 24
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/audio_stream_sequencer.sv
// Pairs ADC left/right samples into stereo frames, applies the run-time mode, buffers the
// frames in a small FIFO and replays them to the DAC left then right.
module audio_stream_sequencer #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned OVF_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  mode,
    audio_stream_sequencer_if.slave     adc_l,
    audio_stream_sequencer_if.slave     adc_r,
    audio_stream_sequencer_if.master    dac_l,
    audio_stream_sequencer_if.master    dac_r,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [OVF_W-1:0]            overflow_count
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {CapL, CapR} cap_state_e;
    typedef enum logic [1:0] {PlayIdle, PlayL, PlayR} play_state_e;

    cap_state_e  cap_q, cap_d;
    play_state_e play_q, play_d;

    logic [DATA_W-1:0] left_q;
    logic              l_fire, r_fire;

    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0]      proc_l, proc_r;

    logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic [OVF_W-1:0]  ovf_q;
    logic              empty, full, pop, push_ok, drop;

    logic [DATA_W-1:0] out_l_q, out_r_q;

    // Capture FSM: left then right, the ADC side is never otherwise stalled.
    always_comb begin
        adc_l.ready = !reset && (cap_q == CapL);
        adc_r.ready = !reset && (cap_q == CapR);
        l_fire      = adc_l.valid && adc_l.ready;
        r_fire      = adc_r.valid && adc_r.ready;
        cap_d       = cap_q;
        if (l_fire) begin
            cap_d = CapR;
        end else if (r_fire) begin
            cap_d = CapL;
        end
    end

    // Sign-extended difference halved with floor; the result always fits DATA_W bits.
    always_comb begin
        diff   = $signed({left_q[DATA_W-1], left_q}) -
                 $signed({adc_r.data[DATA_W-1], adc_r.data});
        proc_l = left_q;
        proc_r = adc_r.data;
        case (mode)
            2'd1: begin
                proc_l = '0;
                proc_r = '0;
            end
            2'd2: begin
                proc_l = DATA_W'(diff >>> 1);
                proc_r = DATA_W'(diff >>> 1);
            end
            2'd3: begin
                proc_l = adc_r.data;
                proc_r = left_q;
            end
            default: begin
                proc_l = left_q;
                proc_r = adc_r.data;
            end
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == FullCount);
    assign push_ok = r_fire && (!full || pop);
    assign drop    = r_fire && full && !pop;

    // Playback FSM: the frame in the output registers is outside the FIFO count.
    always_comb begin
        play_d      = play_q;
        pop         = 1'b0;
        dac_l.valid = !reset && (play_q == PlayL);
        dac_r.valid = !reset && (play_q == PlayR);
        unique case (play_q)
            PlayIdle: begin
                if (!empty) begin
                    pop    = 1'b1;
                    play_d = PlayL;
                end
            end
            PlayL: begin
                if (dac_l.ready) begin
                    play_d = PlayR;
                end
            end
            PlayR: begin
                if (dac_r.ready) begin
                    if (!empty) begin
                        pop    = 1'b1;
                        play_d = PlayL;
                    end else begin
                        play_d = PlayIdle;
                    end
                end
            end
            default: play_d = PlayIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q    <= CapL;
            play_q   <= PlayIdle;
            left_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
            out_l_q  <= '0;
            out_r_q  <= '0;
        end else begin
            cap_q  <= cap_d;
            play_q <= play_d;
            if (l_fire) begin
                left_q <= adc_l.data;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                out_l_q  <= mem_l[rd_ptr_q];
                out_r_q  <= mem_r[rd_ptr_q];
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (ovf_q != '1)) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_l[wr_ptr_q] <= proc_l;
            mem_r[wr_ptr_q] <= proc_r;
        end
    end

    assign dac_l.data     = out_l_q;
    assign dac_r.data     = out_r_q;
    assign fifo_level     = count_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Randomized scoreboard bench for audio_stream_sequencer with directed boundary scenarios.
module tb_audio_stream_sequencer;
    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OVF_W = 16;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [1:0]              mode;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic [OVF_W-1:0]        overflow_count;

    audio_stream_sequencer_if #(.DATA_W(DW)) adc_l_if ();
    audio_stream_sequencer_if #(.DATA_W(DW)) adc_r_if ();
    audio_stream_sequencer_if #(.DATA_W(DW)) dac_l_if ();
    audio_stream_sequencer_if #(.DATA_W(DW)) dac_r_if ();

    audio_stream_sequencer #(
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH),
        .OVF_W(OVF_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .adc_l(adc_l_if),
        .adc_r(adc_r_if),
        .dac_l(dac_l_if),
        .dac_r(dac_r_if),
        .fifo_level(fifo_level),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_l_q[$];
    logic [DW-1:0] exp_r_q[$];
    int frames_in = 0;
    int frames_out = 0;
    bit rand_ready = 1'b0;
    bit force_l_rdy = 1'b0;
    bit force_r_rdy = 1'b0;
    bit left_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: the stereo frame the DAC should see for a given mode and ADC pair.
    function automatic void model(input logic [1:0] m, input logic [DW-1:0] l,
                                  input logic [DW-1:0] r, output logic [DW-1:0] el,
                                  output logic [DW-1:0] er);
        longint sl, sr, d;
        sl = longint'($signed(l));
        sr = longint'($signed(r));
        d  = (sl - sr) >>> 1;
        case (m)
            2'd0: begin el = l; er = r; end
            2'd1: begin el = '0; er = '0; end
            2'd2: begin el = d[DW-1:0]; er = d[DW-1:0]; end
            default: begin el = r; er = l; end
        endcase
    endfunction

    task automatic adc_send(input bit right, input logic [DW-1:0] d);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        if (right) begin
            adc_r_if.data  = d;
            adc_r_if.valid = 1'b1;
        end else begin
            adc_l_if.data  = d;
            adc_l_if.valid = 1'b1;
        end
        while (!done) begin
            @(negedge clk);
            if ((right ? adc_r_if.ready : adc_l_if.ready) == 1'b1) begin
                done = 1'b1;
            end else if (n++ > 100) begin
                fail_bound(right ? "adc_r_accept" : "adc_l_accept");
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (right) adc_r_if.valid = 1'b0;
        else adc_l_if.valid = 1'b0;
    endtask

    task automatic send_raw(input logic [1:0] m, input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input bit expect_out, input logic [DW-1:0] el,
                            input logic [DW-1:0] er, input int gap);
        adc_send(1'b0, l);
        cyc(gap);
        mode = m;
        if (expect_out) begin
            exp_l_q.push_back(el);
            exp_r_q.push_back(er);
            frames_in++;
        end
        adc_send(1'b1, r);
    endtask

    task automatic send_frame(input logic [1:0] m, input logic [DW-1:0] l,
                              input logic [DW-1:0] r, input bit expect_out, input int gap);
        logic [DW-1:0] el, er;
        model(m, l, r, el, er);
        send_raw(m, l, r, expect_out, el, er, gap);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_l_q.size() != 0 || exp_r_q.size() != 0 || fifo_level != 0 ||
                dac_l_if.valid || dac_r_if.valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n < 500), 64'd1);
        cyc(1);
    endtask

    // DAC ready driver: sole writer of the DAC ready lines.
    initial begin
        dac_l_if.ready = 1'b0;
        dac_r_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) begin
                dac_l_if.ready = ($urandom_range(0, 3) != 0);
                dac_r_if.ready = ($urandom_range(0, 3) != 0);
            end else begin
                dac_l_if.ready = force_l_rdy;
                dac_r_if.ready = force_r_rdy;
            end
        end
    end

    // Monitor: pops the scoreboard on every DAC handshake and checks channel ordering.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                left_pending = 1'b0;
                frames_out   = 0;
            end else begin
                if (dac_l_if.valid || dac_r_if.valid) begin
                    check("dac_valid_exclusive", 64'(dac_l_if.valid && dac_r_if.valid), 64'd0);
                end
                if (dac_r_if.valid) begin
                    check("dac_r_after_l", 64'(left_pending), 64'd1);
                end
                if (dac_l_if.valid && dac_l_if.ready) begin
                    if (exp_l_q.size() == 0) fail_bound("unexpected_dac_l");
                    else check("dac_l_data", dac_l_if.data, exp_l_q.pop_front());
                    left_pending = 1'b1;
                end
                if (dac_r_if.valid && dac_r_if.ready) begin
                    if (exp_r_q.size() == 0) fail_bound("unexpected_dac_r");
                    else check("dac_r_data", dac_r_if.data, exp_r_q.pop_front());
                    left_pending = 1'b0;
                    frames_out++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] l, r, held;
        logic [1:0]    m;
        int            n;

        reset          = 1'b1;
        mode           = 2'd0;
        adc_l_if.data  = '0;
        adc_l_if.valid = 1'b0;
        adc_r_if.data  = '0;
        adc_r_if.valid = 1'b0;
        cyc(2);
        @(negedge clk);
        check("rst_adc_l_ready", 64'(adc_l_if.ready), 64'd0);
        check("rst_adc_r_ready", 64'(adc_r_if.ready), 64'd0);
        check("rst_dac_l_valid", 64'(dac_l_if.valid), 64'd0);
        check("rst_dac_r_valid", 64'(dac_r_if.valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_overflow", 64'(overflow_count), 64'd0);
        check("rst_dac_l_data", dac_l_if.data, 64'd0);
        check("rst_dac_r_data", dac_r_if.data, 64'd0);
        check("idle_adc_l_ready", 64'(adc_l_if.ready), 64'd1);
        check("idle_adc_r_ready", 64'(adc_r_if.ready), 64'd0);

        // Loopback latency
        force_l_rdy = 1'b1;
        force_r_rdy = 1'b1;
        cyc(2);
        send_frame(2'd0, 24'h123456, 24'hABCDEF, 1'b1, 0);
        check("lat_l_valid_early", 64'(dac_l_if.valid), 64'd0);
        cyc(1);
        check("lat_l_valid", 64'(dac_l_if.valid), 64'd1);
        check("lat_l_data", dac_l_if.data, 64'h123456);
        cyc(1);
        check("lat_r_valid", 64'(dac_r_if.valid), 64'd1);
        check("lat_r_data", dac_r_if.data, 64'hABCDEF);
        check("lat_l_dropped", 64'(dac_l_if.valid), 64'd0);
        wait_drain("drain_loopback");

        // Vocal-cancel corner values
        send_raw(2'd2, 24'h000100, 24'h000040, 1'b1, 24'h000060, 24'h000060, 0);
        send_raw(2'd2, 24'h800000, 24'h7FFFFF, 1'b1, 24'h800000, 24'h800000, 1);
        send_raw(2'd2, 24'h7FFFFF, 24'h800000, 1'b1, 24'h7FFFFF, 24'h7FFFFF, 0);
        send_raw(2'd1, 24'h555555, 24'h2AAAAA, 1'b1, 24'h000000, 24'h000000, 0);
        send_raw(2'd3, 24'h000001, 24'hFFFFFE, 1'b1, 24'hFFFFFE, 24'h000001, 0);
        wait_drain("drain_modes");

        // Randomized traffic, throttled so the FIFO never overflows
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            n = 0;
            while ((frames_in - frames_out) >= int'(DEPTH) && n < 1000) begin
                cyc(1);
                n++;
            end
            if (n >= 1000) fail_bound("throttle_wait");
            l = DW'($urandom);
            r = DW'($urandom);
            m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) l = 24'h800000;
            if ($urandom_range(0, 7) == 0) r = 24'h7FFFFF;
            send_frame(m, l, r, 1'b1, int'($urandom_range(0, 2)));
        end
        rand_ready = 1'b0;
        wait_drain("drain_random");
        check("random_no_overflow", 64'(overflow_count), 64'd0);

        // Overflow: six frames into a stalled DAC
        force_l_rdy = 1'b0;
        force_r_rdy = 1'b0;
        cyc(2);
        for (int i = 0; i < 6; i++) begin
            send_frame(2'd0, DW'(24'h100000 + i), DW'(24'h200000 + i), (i != 5), 0);
        end
        cyc(2);
        check("ovf_fifo_level", 64'(fifo_level), 64'(DEPTH));
        check("ovf_count", 64'(overflow_count), 64'd1);
        check("ovf_head_valid", 64'(dac_l_if.valid), 64'd1);
        check("ovf_head_data", dac_l_if.data, 64'h100000);
        force_l_rdy = 1'b1;
        force_r_rdy = 1'b1;
        wait_drain("drain_overflow");
        cyc(20);
        check("ovf_sixth_absent", 64'(dac_l_if.valid), 64'd0);
        check("ovf_count_hold", 64'(overflow_count), 64'd1);

        // Right sample offered while waiting for left
        adc_r_if.data  = 24'h0BADBE;
        adc_r_if.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("order_adc_r_ready", 64'(adc_r_if.ready), 64'd0);
        end
        cyc(1);
        adc_r_if.valid = 1'b0;
        cyc(3);
        check("order_fifo_level", 64'(fifo_level), 64'd0);
        check("order_no_output", 64'(dac_l_if.valid), 64'd0);
        check("order_still_cap_l", 64'(adc_l_if.ready), 64'd1);

        // DAC left stall
        force_l_rdy = 1'b0;
        cyc(2);
        send_frame(2'd0, 24'h3C3C3C, 24'hC3C3C3, 1'b1, 0);
        n = 0;
        while (!dac_l_if.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_l_offered", 64'(dac_l_if.valid), 64'd1);
        held = dac_l_if.data;
        check("stall_l_first", held, 64'h3C3C3C);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_l_data", dac_l_if.data, held);
            check("stall_r_valid", 64'(dac_r_if.valid), 64'd0);
        end
        force_l_rdy = 1'b1;
        wait_drain("drain_stall");

        // Reset with frames buffered, one in playback and a half-captured frame
        force_l_rdy = 1'b0;
        force_r_rdy = 1'b0;
        cyc(2);
        send_frame(2'd0, 24'h111111, 24'h222222, 1'b1, 0);
        send_frame(2'd0, 24'h333333, 24'h444444, 1'b1, 0);
        adc_send(1'b0, 24'h555555);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_adc_r_ready", 64'(adc_r_if.ready), 64'd0);
        check("mid_rst_dac_l_valid", 64'(dac_l_if.valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_l_q.delete();
        exp_r_q.delete();
        frames_in = 0;
        @(negedge clk);
        check("post_rst_dac_l_valid", 64'(dac_l_if.valid), 64'd0);
        check("post_rst_dac_r_valid", 64'(dac_r_if.valid), 64'd0);
        check("post_rst_fifo_level", 64'(fifo_level), 64'd0);
        check("post_rst_dac_l_data", dac_l_if.data, 64'd0);
        check("post_rst_adc_l_ready", 64'(adc_l_if.ready), 64'd1);
        force_l_rdy = 1'b1;
        force_r_rdy = 1'b1;
        cyc(1);
        send_frame(2'd3, 24'h0A0B0C, 24'h0D0E0F, 1'b1, 0);
        wait_drain("drain_post_reset");

        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
